// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Opcode/funct encodings, ALUOp encodings and the control
//               bundle type shared by the ID-stage decoder and ID/EX pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam int C_OPCODE_W = 6;
    localparam int C_FUNCT_W  = 6;
    localparam int C_ALU_OP_W = 4;

    // Primary opcodes, instruction[31:26]
    localparam logic [C_OPCODE_W-1:0] C_OP_R    = 6'b000000;
    localparam logic [C_OPCODE_W-1:0] C_OP_ADDI = 6'b001000;
    localparam logic [C_OPCODE_W-1:0] C_OP_ORI  = 6'b001101;
    localparam logic [C_OPCODE_W-1:0] C_OP_ANDI = 6'b001100;
    localparam logic [C_OPCODE_W-1:0] C_OP_BEQ  = 6'b000100;
    localparam logic [C_OPCODE_W-1:0] C_OP_BNE  = 6'b000101;
    localparam logic [C_OPCODE_W-1:0] C_OP_LW   = 6'b100011;
    localparam logic [C_OPCODE_W-1:0] C_OP_SW   = 6'b101011;
    localparam logic [C_OPCODE_W-1:0] C_OP_LUI  = 6'b001111;
    localparam logic [C_OPCODE_W-1:0] C_OP_J    = 6'b000010;
    localparam logic [C_OPCODE_W-1:0] C_OP_JAL  = 6'b000011;

    // R-type funct that turns the instruction into a register jump
    localparam logic [C_FUNCT_W-1:0]  C_FUNCT_JR = 6'b001000;

    // ALUOp encodings understood by the EX-stage ALU control
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_RTYPE = 4'b0111;
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_ADDI  = 4'b0100;
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_ORI   = 4'b0101;
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_ANDI  = 4'b0110;
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_BR    = 4'b0001;
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_LW    = 4'b0010;
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_SW    = 4'b0011;
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_LUI   = 4'b1000;
    localparam logic [C_ALU_OP_W-1:0] C_ALUOP_NONE  = 4'b0000;

    // Control bundle carried from ID into EX
    typedef struct packed {
        logic [C_ALU_OP_W-1:0] alu_op;
        logic                  reg_dst;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  branch_eq;
        logic                  branch_ne;
        logic                  jump;
        logic                  jal;
        logic                  jr;
    } ctrl_t;

    // All-zero bundle: a pipeline bubble
    localparam ctrl_t C_CTRL_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/main_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : main_control_decoder
// Description : Pure combinational main decoder: opcode/funct -> control
//               bundle, illegal-opcode flag and rt-as-source flag.
// Revision    : 1.0 - initial release
// ============================================================================
module main_control_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [C_OPCODE_W-1:0] i_opcode,
    input  logic [C_FUNCT_W-1:0]  i_funct,
    output ctrl_t                 o_ctrl,
    output logic                  o_illegal,
    output logic                  o_uses_rt
);

    // Opcode decode; every field not named for an opcode stays 0
    always_comb begin
        o_ctrl    = C_CTRL_NOP;
        o_illegal = 1'b0;
        o_uses_rt = 1'b0;
        case (i_opcode)
            C_OP_R: begin
                o_ctrl.alu_op    = C_ALUOP_RTYPE;
                o_ctrl.reg_dst   = 1'b1;
                o_uses_rt        = 1'b1;
                if (i_funct == C_FUNCT_JR) begin
                    o_ctrl.jr        = 1'b1;
                    o_ctrl.reg_write = 1'b0;
                end else begin
                    o_ctrl.reg_write = 1'b1;
                end
            end
            C_OP_ADDI: begin
                o_ctrl.alu_op    = C_ALUOP_ADDI;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            C_OP_ORI: begin
                o_ctrl.alu_op    = C_ALUOP_ORI;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            C_OP_ANDI: begin
                o_ctrl.alu_op    = C_ALUOP_ANDI;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            C_OP_BEQ: begin
                o_ctrl.alu_op    = C_ALUOP_BR;
                o_ctrl.branch_eq = 1'b1;
                o_uses_rt        = 1'b1;
            end
            C_OP_BNE: begin
                o_ctrl.alu_op    = C_ALUOP_BR;
                o_ctrl.branch_ne = 1'b1;
                o_uses_rt        = 1'b1;
            end
            C_OP_LW: begin
                o_ctrl.alu_op     = C_ALUOP_LW;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            C_OP_SW: begin
                o_ctrl.alu_op    = C_ALUOP_SW;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_uses_rt        = 1'b1;
            end
            C_OP_LUI: begin
                o_ctrl.alu_op    = C_ALUOP_LUI;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            C_OP_J: begin
                o_ctrl.alu_op = C_ALUOP_NONE;
                o_ctrl.jump   = 1'b1;
            end
            C_OP_JAL: begin
                o_ctrl.alu_op    = C_ALUOP_NONE;
                o_ctrl.jump      = 1'b1;
                o_ctrl.jal       = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_control_pipe
// Description : Main control decode plus ID/EX control register with
//               load-use hazard detection, bubble insertion, flush/hold
//               handling and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_control_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int BUBBLE_CNT_W = 16,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [C_OPCODE_W-1:0]   id_opcode,
    input  logic [C_FUNCT_W-1:0]    id_funct,
    input  logic [REG_ADDR_W-1:0]   id_rs,
    input  logic [REG_ADDR_W-1:0]   id_rt,
    input  logic                    flush,
    input  logic                    hold,
    output logic [C_ALU_OP_W-1:0]   ex_alu_op,
    output logic [C_FUNCT_W-1:0]    ex_funct,
    output logic [REG_ADDR_W-1:0]   ex_rt,
    output logic                    ex_reg_dst,
    output logic                    ex_alu_src,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_mem_to_reg,
    output logic                    ex_reg_write,
    output logic                    ex_branch_eq,
    output logic                    ex_branch_ne,
    output logic                    ex_jump,
    output logic                    ex_jal,
    output logic                    ex_jr,
    output logic                    ex_valid,
    output logic                    ex_illegal,
    output logic                    pc_write,
    output logic                    if_id_write,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);

    localparam logic [BUBBLE_CNT_W-1:0] c_cnt_one = {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};

    ctrl_t                   w_dec_ctrl;
    logic                    w_dec_illegal;
    logic                    w_uses_rt;
    logic                    w_load_use;

    ctrl_t                   r_ex_ctrl;
    logic                    r_ex_illegal;
    logic                    r_ex_valid;
    logic [REG_ADDR_W-1:0]   r_ex_rt;
    logic [C_FUNCT_W-1:0]    r_ex_funct;
    logic [BUBBLE_CNT_W-1:0] r_bubble_count;

    main_control_decoder u_dec (
        .i_opcode  (id_opcode),
        .i_funct   (id_funct),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_uses_rt (w_uses_rt)
    );

    // Load in EX whose destination feeds a source of the ID instruction; $zero never hazards
    always_comb begin
        w_load_use = id_valid & r_ex_valid & r_ex_ctrl.mem_read
                   & (r_ex_rt != '0)
                   & ((r_ex_rt == id_rs) | (w_uses_rt & (r_ex_rt == id_rt)));
    end

    // Front-end write enables: a flushed ID instruction is discarded, so it never stalls
    always_comb begin
        pc_write    = ~hold & (flush | ~w_load_use);
        if_id_write = ~hold & (flush | ~w_load_use);
    end

    // ID/EX control register: flush > hold > load-use bubble > normal advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_ctrl      <= C_CTRL_NOP;
            r_ex_illegal   <= 1'b0;
            r_ex_valid     <= 1'b0;
            r_ex_rt        <= '0;
            r_ex_funct     <= '0;
            r_bubble_count <= '0;
        end else if (flush) begin
            r_ex_ctrl    <= C_CTRL_NOP;
            r_ex_illegal <= 1'b0;
            r_ex_valid   <= 1'b0;
            r_ex_rt      <= '0;
            r_ex_funct   <= '0;
        end else if (hold) begin
            r_ex_ctrl      <= r_ex_ctrl;
            r_ex_illegal   <= r_ex_illegal;
            r_ex_valid     <= r_ex_valid;
            r_ex_rt        <= r_ex_rt;
            r_ex_funct     <= r_ex_funct;
            r_bubble_count <= r_bubble_count;
        end else if (w_load_use) begin
            r_ex_ctrl    <= C_CTRL_NOP;
            r_ex_illegal <= 1'b0;
            r_ex_valid   <= 1'b0;
            r_ex_rt      <= '0;
            r_ex_funct   <= '0;
            if (r_bubble_count != '1) begin
                r_bubble_count <= r_bubble_count + c_cnt_one;
            end
        end else begin
            r_ex_ctrl    <= id_valid ? w_dec_ctrl : C_CTRL_NOP;
            r_ex_illegal <= id_valid & w_dec_illegal;
            r_ex_valid   <= id_valid;
            r_ex_rt      <= id_rt;
            r_ex_funct   <= id_funct;
        end
    end

    // Output mapping of the EX-stage control register
    always_comb begin
        ex_alu_op     = r_ex_ctrl.alu_op;
        ex_reg_dst    = r_ex_ctrl.reg_dst;
        ex_alu_src    = r_ex_ctrl.alu_src;
        ex_mem_read   = r_ex_ctrl.mem_read;
        ex_mem_write  = r_ex_ctrl.mem_write;
        ex_mem_to_reg = r_ex_ctrl.mem_to_reg;
        ex_reg_write  = r_ex_ctrl.reg_write;
        ex_branch_eq  = r_ex_ctrl.branch_eq;
        ex_branch_ne  = r_ex_ctrl.branch_ne;
        ex_jump       = r_ex_ctrl.jump;
        ex_jal        = r_ex_ctrl.jal;
        ex_jr         = r_ex_ctrl.jr;
        ex_valid      = r_ex_valid;
        ex_illegal    = r_ex_illegal;
        ex_rt         = r_ex_rt;
        ex_funct      = r_ex_funct;
        bubble_count  = r_bubble_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_control_pipe
// Description : Directed self-checking bench for id_ex_control_pipe. A second
//               narrow-counter instance shares the stimulus so counter
//               saturation is reached in a few dozen cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_control_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [5:0] id_funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       flush;
    logic       hold;

    logic [3:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_rt;
    logic        ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic        ex_branch_eq, ex_branch_ne, ex_jump, ex_jal, ex_jr, ex_valid, ex_illegal;
    logic        pc_write, if_id_write;
    logic [15:0] bubble_count;

    logic [3:0]  s_alu_op;
    logic [5:0]  s_funct;
    logic [4:0]  s_rt;
    logic        s_reg_dst, s_alu_src, s_mem_read, s_mem_write, s_mem_to_reg, s_reg_write;
    logic        s_branch_eq, s_branch_ne, s_jump, s_jal, s_jr, s_valid, s_illegal;
    logic        s_pc_write, s_if_id_write;
    logic [3:0]  s_bubble_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    int exp_small = 0;

    always #5 clk = ~clk;

    id_ex_control_pipe dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .hold(hold),
        .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .ex_rt(ex_rt),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne), .ex_jump(ex_jump),
        .ex_jal(ex_jal), .ex_jr(ex_jr), .ex_valid(ex_valid), .ex_illegal(ex_illegal),
        .pc_write(pc_write), .if_id_write(if_id_write), .bubble_count(bubble_count)
    );

    id_ex_control_pipe #(.BUBBLE_CNT_W(4), .REG_ADDR_W(5)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .hold(hold),
        .ex_alu_op(s_alu_op), .ex_funct(s_funct), .ex_rt(s_rt),
        .ex_reg_dst(s_reg_dst), .ex_alu_src(s_alu_src), .ex_mem_read(s_mem_read),
        .ex_mem_write(s_mem_write), .ex_mem_to_reg(s_mem_to_reg), .ex_reg_write(s_reg_write),
        .ex_branch_eq(s_branch_eq), .ex_branch_ne(s_branch_ne), .ex_jump(s_jump),
        .ex_jal(s_jal), .ex_jr(s_jr), .ex_valid(s_valid), .ex_illegal(s_illegal),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .bubble_count(s_bubble_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt);
        id_valid  = v;
        id_opcode = op;
        id_funct  = fn;
        id_rs     = rs;
        id_rt     = rt;
    endtask

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0; hold = 1'b0;
        drive(1'b0, 6'b0, 6'b0, 5'd0, 5'd0);
        #3;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        checks++; if (ex_alu_op !== 4'b0000) begin errors++; $display("FAIL reset_alu_op got %b want 0000", ex_alu_op); end
        checks++; if (bubble_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bubble_count); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write got %b want 1", pc_write); end
        tick; tick;
        reset = 1'b1;
    endtask

    task automatic test_addi;
        drive(1'b1, 6'b001000, 6'b0, 5'd1, 5'd2);
        tick;
        checks++; if (ex_alu_op !== 4'b0100) begin errors++; $display("FAIL addi_alu_op got %b want 0100", ex_alu_op); end
        checks++; if ({ex_alu_src, ex_reg_write, ex_valid} !== 3'b111) begin errors++; $display("FAIL addi_ctrl got %b want 111", {ex_alu_src, ex_reg_write, ex_valid}); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL addi_pc_write got %b want 1", pc_write); end
        checks++; if (ex_rt !== 5'd2) begin errors++; $display("FAIL addi_rt got %0d want 2", ex_rt); end
    endtask

    task automatic test_load_use_rtype;
        drive(1'b1, 6'b100011, 6'b0, 5'd1, 5'd5);
        tick;
        checks++; if ({ex_mem_read, ex_mem_to_reg, ex_alu_op} !== 6'b110010) begin errors++; $display("FAIL lw_ctrl got %b want 110010", {ex_mem_read, ex_mem_to_reg, ex_alu_op}); end
        drive(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd6);
        #1;
        checks++; if ({pc_write, if_id_write} !== 2'b00) begin errors++; $display("FAIL lu_stall_en got %b want 00", {pc_write, if_id_write}); end
        tick;
        exp_count++;
        checks++; if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000) begin errors++; $display("FAIL lu_bubble got %b want 000", {ex_valid, ex_mem_read, ex_reg_write}); end
        checks++; if (bubble_count !== 16'(exp_count)) begin errors++; $display("FAIL lu_count got %0d want %0d", bubble_count, exp_count); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_release got %b want 1", pc_write); end
        tick;
        checks++; if ({ex_alu_op, ex_reg_dst, ex_valid} !== 6'b011111) begin errors++; $display("FAIL lu_add got %b want 011111", {ex_alu_op, ex_reg_dst, ex_valid}); end
    endtask

    task automatic test_load_use_sw;
        drive(1'b1, 6'b100011, 6'b0, 5'd1, 5'd5);
        tick;
        drive(1'b1, 6'b101011, 6'b0, 5'd3, 5'd5);
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL sw_stall got %b want 0", pc_write); end
        tick;
        exp_count++;
        checks++; if (bubble_count !== 16'(exp_count)) begin errors++; $display("FAIL sw_count got %0d want %0d", bubble_count, exp_count); end
        tick;
        checks++; if ({ex_mem_write, ex_alu_op} !== 5'b10011) begin errors++; $display("FAIL sw_ctrl got %b want 10011", {ex_mem_write, ex_alu_op}); end
    endtask

    task automatic test_zero_reg;
        drive(1'b1, 6'b100011, 6'b0, 5'd1, 5'd0);
        tick;
        drive(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL zero_no_stall got %b want 1", pc_write); end
        tick;
        checks++; if ({ex_valid, ex_alu_op} !== 5'b10111) begin errors++; $display("FAIL zero_add got %b want 10111", {ex_valid, ex_alu_op}); end
        checks++; if (bubble_count !== 16'(exp_count)) begin errors++; $display("FAIL zero_count got %0d want %0d", bubble_count, exp_count); end
    endtask

    task automatic test_no_uses_rt_and_flush;
        drive(1'b1, 6'b100011, 6'b0, 5'd1, 5'd7);
        tick;
        drive(1'b1, 6'b001000, 6'b0, 5'd2, 5'd7);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL imm_rt_no_stall got %b want 1", pc_write); end
        tick;
        checks++; if (ex_alu_op !== 4'b0100) begin errors++; $display("FAIL imm_rt_addi got %b want 0100", ex_alu_op); end
        drive(1'b1, 6'b100011, 6'b0, 5'd1, 5'd7);
        tick;
        drive(1'b1, 6'b000000, 6'b100000, 5'd7, 5'd1);
        flush = 1'b1;
        #1;
        checks++; if ({pc_write, if_id_write} !== 2'b11) begin errors++; $display("FAIL flush_en got %b want 11", {pc_write, if_id_write}); end
        tick;
        flush = 1'b0;
        checks++; if ({ex_valid, ex_alu_op, ex_reg_write} !== 6'b000000) begin errors++; $display("FAIL flush_bubble got %b want 000000", {ex_valid, ex_alu_op, ex_reg_write}); end
        checks++; if (bubble_count !== 16'(exp_count)) begin errors++; $display("FAIL flush_count got %0d want %0d", bubble_count, exp_count); end
    endtask

    task automatic test_hold;
        drive(1'b1, 6'b000100, 6'b0, 5'd1, 5'd2);
        tick;
        drive(1'b1, 6'b001101, 6'b0, 5'd3, 5'd4);
        hold = 1'b1;
        #1;
        checks++; if ({pc_write, if_id_write} !== 2'b00) begin errors++; $display("FAIL hold_en got %b want 00", {pc_write, if_id_write}); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if ({ex_branch_eq, ex_alu_op} !== 5'b10001) begin errors++; $display("FAIL hold_frozen cyc %0d got %b want 10001", i, {ex_branch_eq, ex_alu_op}); end
        end
        hold = 1'b0;
        tick;
        checks++; if ({ex_branch_eq, ex_alu_op} !== 5'b00101) begin errors++; $display("FAIL hold_release got %b want 00101", {ex_branch_eq, ex_alu_op}); end
    endtask

    task automatic test_hold_load_use;
        drive(1'b1, 6'b100011, 6'b0, 5'd1, 5'd5);
        tick;
        drive(1'b1, 6'b000000, 6'b100010, 5'd5, 5'd2);
        hold = 1'b1;
        tick; tick;
        checks++; if ({ex_mem_read, ex_valid} !== 2'b11) begin errors++; $display("FAIL hold_lu_frozen got %b want 11", {ex_mem_read, ex_valid}); end
        checks++; if (bubble_count !== 16'(exp_count)) begin errors++; $display("FAIL hold_lu_count got %0d want %0d", bubble_count, exp_count); end
        hold = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL hold_lu_stall got %b want 0", pc_write); end
        tick;
        exp_count++;
        checks++; if (bubble_count !== 16'(exp_count)) begin errors++; $display("FAIL hold_lu_bubble_count got %0d want %0d", bubble_count, exp_count); end
        tick;
        checks++; if ({ex_funct, ex_alu_op} !== 10'b1000100111) begin errors++; $display("FAIL hold_lu_sub got %b want 1000100111", {ex_funct, ex_alu_op}); end
    endtask

    task automatic test_decode_misc;
        drive(1'b1, 6'b111111, 6'b0, 5'd1, 5'd2);
        tick;
        checks++; if ({ex_illegal, ex_reg_write, ex_mem_write, ex_alu_op} !== 7'b1000000) begin errors++; $display("FAIL illegal got %b want 1000000", {ex_illegal, ex_reg_write, ex_mem_write, ex_alu_op}); end
        drive(1'b1, 6'b000000, 6'b001000, 5'd31, 5'd0);
        tick;
        checks++; if ({ex_jr, ex_reg_write, ex_reg_dst, ex_illegal, ex_alu_op} !== 8'b10100111) begin errors++; $display("FAIL jr got %b want 10100111", {ex_jr, ex_reg_write, ex_reg_dst, ex_illegal, ex_alu_op}); end
        drive(1'b1, 6'b000011, 6'b0, 5'd0, 5'd0);
        tick;
        checks++; if ({ex_jump, ex_jal, ex_reg_write, ex_jr, ex_alu_op} !== 8'b11100000) begin errors++; $display("FAIL jal got %b want 11100000", {ex_jump, ex_jal, ex_reg_write, ex_jr, ex_alu_op}); end
        drive(1'b1, 6'b001111, 6'b0, 5'd0, 5'd9);
        tick;
        checks++; if ({ex_alu_src, ex_reg_write, ex_alu_op} !== 6'b111000) begin errors++; $display("FAIL lui got %b want 111000", {ex_alu_src, ex_reg_write, ex_alu_op}); end
        drive(1'b0, 6'b001000, 6'b010101, 5'd1, 5'd9);
        tick;
        checks++; if ({ex_valid, ex_reg_write, ex_alu_src, ex_alu_op} !== 7'b0000000) begin errors++; $display("FAIL invalid_ctrl got %b want 0000000", {ex_valid, ex_reg_write, ex_alu_src, ex_alu_op}); end
        checks++; if ({ex_rt, ex_funct} !== 11'b01001010101) begin errors++; $display("FAIL invalid_fields got %b want 01001010101", {ex_rt, ex_funct}); end
    endtask

    task automatic test_saturation;
        drive(1'b1, 6'b100011, 6'b0, 5'd5, 5'd5);
        tick;
        for (int i = 0; i < 20; i++) begin
            tick;
            tick;
            exp_count++;
        end
        exp_small = (exp_count > 15) ? 15 : exp_count;
        checks++; if (bubble_count !== 16'(exp_count)) begin errors++; $display("FAIL sat_wide_count got %0d want %0d", bubble_count, exp_count); end
        checks++; if (s_bubble_count !== 4'(exp_small)) begin errors++; $display("FAIL sat_narrow_count got %0d want %0d", s_bubble_count, exp_small); end
    endtask

    task automatic test_reset_mid_stall;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL mid_stall_pre got %b want 0", pc_write); end
        reset = 1'b0;
        #1;
        checks++; if ({ex_valid, ex_mem_read, ex_alu_op} !== 6'b000000) begin errors++; $display("FAIL async_reset_ex got %b want 000000", {ex_valid, ex_mem_read, ex_alu_op}); end
        checks++; if (bubble_count !== 16'd0) begin errors++; $display("FAIL async_reset_count got %0d want 0", bubble_count); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL async_reset_pc got %b want 1", pc_write); end
        tick;
        reset = 1'b1;
        tick;
        checks++; if ({ex_valid, ex_mem_read} !== 2'b11) begin errors++; $display("FAIL post_reset_lw got %b want 11", {ex_valid, ex_mem_read}); end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load_use_rtype;
        test_load_use_sw;
        test_zero_reg;
        test_no_uses_rt_and_flush;
        test_hold;
        test_hold_load_use;
        test_decode_misc;
        test_saturation;
        test_reset_mid_stall;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_control_pipe.md
Name: id_ex_control_pipe

Overview:
- Main control decoder plus ID/EX control pipeline register for the pipelined MIPS core; it produces the 4-bit ALUOp and funct consumed by the EX-stage ALU control.
- Decodes the ID-stage opcode/funct into a control bundle and registers it into EX.
- Detects load-use hazards against the instruction currently in EX, inserts bubbles, and gates PC / IF-ID writes.
- Honours branch/jump flush and an external pipeline hold.

Parameters:
- BUBBLE_CNT_W, 16, width of the saturating bubble counter
- REG_ADDR_W, 5, register-file address width

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low reset
- id_valid  input  1  IF/ID holds a real instruction
- id_opcode  input  6  instruction[31:26]
- id_funct  input  6  instruction[5:0]
- id_rs  input  REG_ADDR_W  instruction[25:21]
- id_rt  input  REG_ADDR_W  instruction[20:16]
- flush  input  1  branch/jump resolved taken; squash the ID instruction
- hold  input  1  global pipeline freeze
- ex_alu_op  output  4  ALUOp to EX ALU control
- ex_funct  output  6  registered funct
- ex_rt  output  REG_ADDR_W  registered rt
- ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  output  1 each  datapath controls
- ex_branch_eq, ex_branch_ne, ex_jump, ex_jal, ex_jr  output  1 each  control-flow controls
- ex_valid  output  1  EX slot holds a real instruction
- ex_illegal  output  1  EX instruction had an undecoded opcode
- pc_write  output  1  PC update enable (combinational)
- if_id_write  output  1  IF/ID update enable (combinational)
- bubble_count  output  BUBBLE_CNT_W  load-use bubbles inserted since reset

Behaviour:
- Reset (reset==0, async): all ex_* outputs 0 (bubble), bubble_count 0. pc_write and if_id_write follow the combinational rules below.
- Decode (combinational, ID). Each opcode sets ALUOp and the listed controls; every other control is 0.
  - 000000 R-type: ALUOp 0111, reg_dst, reg_write. If funct==001000: jr=1, reg_write=0.
  - 001000 ADDI: ALUOp 0100, alu_src, reg_write.
  - 001101 ORI: ALUOp 0101, alu_src, reg_write.
  - 001100 ANDI: ALUOp 0110, alu_src, reg_write.
  - 000100 BEQ: ALUOp 0001, branch_eq.
  - 000101 BNE: ALUOp 0001, branch_ne.
  - 100011 LW: ALUOp 0010, alu_src, mem_read, mem_to_reg, reg_write.
  - 101011 SW: ALUOp 0011, alu_src, mem_write.
  - 001111 LUI: ALUOp 1000, alu_src, reg_write.
  - 000010 J: ALUOp 0000, jump.
  - 000011 JAL: ALUOp 0000, jump, jal, reg_write.
  - Any other opcode: ALUOp 0000, all controls 0, illegal=1.
- uses_rt = 1 for R-type, BEQ, BNE, SW; 0 otherwise.
- load_use = id_valid & ex_valid & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (uses_rt & ex_rt==id_rt)).
- Registered update, priority order:
  1. flush: load bubble (all ex_* 0).
  2. hold: keep all ex_* and bubble_count.
  3. load_use: load bubble; bubble_count+1, saturating at all-ones.
  4. Otherwise: load the decoded bundle. ex_rt=id_rt, ex_funct=id_funct, ex_valid=id_valid. If id_valid==0, all controls load 0.
- pc_write = if_id_write = ~hold & (flush | ~load_use). Flush wins over load_use: no stall is taken on a squashed instruction.
- Latency: decode-to-ex_* is 1 cycle. A load-use stall lasts exactly 1 cycle, because the bubble clears ex_mem_read.
- hold asserted while load_use is true: no bubble and no count; the stall resolves after hold deasserts.
- rs/rt==0 never stalls.
- Reset asserted mid-stall: immediate bubble state, counter cleared.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode localparams (R, ADDI, ORI, ANDI, BEQ, BNE, LW, SW, LUI, J, JAL) and FUNCT_JR;
  - ALUOp localparams (0111, 0100, 0101, 0110, 0001, 0010, 0011, 1000, 0000);
  - control-bundle field widths.
- One natural sub-module: main_control_decoder (pure combinational opcode/funct -> bundle + illegal + uses_rt). The pipeline register, hazard logic and counter stay in the top module.

Test Plan:
- Reset release, then ADDI (001000) with id_valid=1 -> next cycle ex_alu_op=0100, ex_alu_src=1, ex_reg_write=1, ex_valid=1, pc_write=1.
- LW rt=5, then ADD rs=5 -> cycle 2: pc_write=0, if_id_write=0. Cycle 3: ex_* bubble, bubble_count=1. Cycle 4: ex_alu_op=0111, ex_reg_dst=1.
- LW rt=5, then SW rs=3 rt=5 -> stall 1 cycle. LW rt=0, then ADD rs=0 -> no stall, count unchanged.
- LW rt=7, then ADDI rs=2 rt=7 (uses_rt=0) -> no stall. Same pair with flush=1 on cycle 2 -> pc_write=1, ex_* bubble, bubble_count unchanged.
- hold=1 for 3 cycles with ORI in ID -> ex_* frozen at the prior instruction, pc_write=0. After release -> ex_alu_op=0101.
- Opcode 111111 -> ex_illegal=1, ex_reg_write=0, ex_mem_write=0. R-type funct 001000 -> ex_jr=1, ex_reg_write=0. Force 65535 load-use events -> bubble_count saturates at 16'hFFFF.
